// File: rtl/timed_sabotuer.sv
// ---------------------------------------------------------------------------
// timed_sabotuer
// Time-controlled fault saboteur placed in-line on a WIDTH-bit datapath net.
// Applies stuck-at-0, stuck-at-1 or bit-flip faults to the bits selected by a
// latched mask. Injection starts a programmable delay after arming and follows
// one of four timing modes: permanent, transient, window or intermittent.
// Data passes through combinationally; only the fault-enable timing is held
// in registers.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_data         : fault-free bus value
//   o_data         : possibly faulty bus value (combinational from i_data)
//   i_arm          : arm request, latches mask/ctrl/mode/dur (IDLE or DONE only)
//   i_clear        : abort to IDLE, wins over arm and every transition
//   i_mask         : bits to sabotage (1 = target)
//   i_ctrl         : 00 stuck-at-0, 01 stuck-at-1, 1x bit flip
//   i_mode         : 00 permanent, 01 transient, 10 window, 11 intermittent
//   i_delay        : cycles from the arm edge to the first faulty cycle
//   i_dur          : window length / intermittent half-period (0 acts as 1)
//   o_active       : fault currently applied to o_data
//   o_done         : transient or window sequence finished
// ---------------------------------------------------------------------------
module timed_sabotuer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_arm,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [1:0]       i_ctrl,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_dur,
  output logic             o_active,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_INJECT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] M_PERM   = 2'b00;
  localparam logic [1:0] M_TRANS  = 2'b01;
  localparam logic [1:0] M_WINDOW = 2'b10;
  localparam logic [1:0] M_INTER  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             done_q, done_d;
  logic             active_q, active_d;

  // Reload values for the duration counter (a duration of 0 counts as 1).
  logic [CNT_W-1:0] arm_dur_m1_c;
  logic [CNT_W-1:0] lat_dur_m1_c;
  assign arm_dur_m1_c = (i_dur == '0) ? '0 : i_dur - CNT_W'(1);
  assign lat_dur_m1_c = (dur_q == '0) ? '0 : dur_q - CNT_W'(1);

  // Next-state and timing control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    mask_d   = mask_q;
    ctrl_d   = ctrl_q;
    mode_d   = mode_q;
    dur_d    = dur_q;
    done_d   = done_q;

    if (i_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            mask_d = i_mask;
            ctrl_d = i_ctrl;
            mode_d = i_mode;
            dur_d  = i_dur;
            done_d = 1'b0;
            if (i_delay == '0) begin
              state_d = S_INJECT;
              phase_d = 1'b1;
              cnt_d   = arm_dur_m1_c;
            end else begin
              state_d = S_WAIT;
              phase_d = 1'b0;
              cnt_d   = i_delay - CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_INJECT;
            phase_d = 1'b1;
            cnt_d   = lat_dur_m1_c;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_INJECT: begin
          case (mode_q)
            M_PERM: begin
            end
            M_TRANS: begin
              state_d = S_DONE;
              phase_d = 1'b0;
              done_d  = 1'b1;
            end
            M_WINDOW: begin
              if (cnt_q == '0) begin
                state_d = S_DONE;
                phase_d = 1'b0;
                done_d  = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            M_INTER: begin
              // Toggle on/off every dur' cycles, starting with the on phase.
              if (cnt_q == '0) begin
                phase_d = ~phase_q;
                cnt_d   = lat_dur_m1_c;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Fault enable follows the next state so o_active is a plain register.
  assign active_d = (state_d == S_INJECT) && phase_d;

  // State and configuration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      mode_q   <= '0;
      dur_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      mode_q   <= mode_d;
      dur_q    <= dur_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  // Zero-latency fault application on the masked bits.
  logic [WIDTH-1:0] eff_mask_c;
  assign eff_mask_c = active_q ? mask_q : '0;

  always_comb begin
    o_data = i_data;
    if (ctrl_q[1]) begin
      o_data = i_data ^ eff_mask_c;
    end else if (ctrl_q[0]) begin
      o_data = i_data | eff_mask_c;
    end else begin
      o_data = i_data & ~eff_mask_c;
    end
  end

  assign o_active = active_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_timed_sabotuer.sv
// ---------------------------------------------------------------------------
// tb_timed_sabotuer
// Directed and randomized bench for timed_sabotuer with a timeline-based
// reference model: for cycle j after the arm edge, activity and completion
// are derived from delay, dur and mode with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_timed_sabotuer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  i_data;
  logic [W-1:0]  o_data;
  logic          i_arm;
  logic          i_clear;
  logic [W-1:0]  i_mask;
  logic [1:0]    i_ctrl;
  logic [1:0]    i_mode;
  logic [CW-1:0] i_delay;
  logic [CW-1:0] i_dur;
  logic          o_active;
  logic          o_done;

  int checks = 0;
  int errors = 0;

  timed_sabotuer #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (i_data),
    .o_data   (o_data),
    .i_arm    (i_arm),
    .i_clear  (i_clear),
    .i_mask   (i_mask),
    .i_ctrl   (i_ctrl),
    .i_mode   (i_mode),
    .i_delay  (i_delay),
    .i_dur    (i_dur),
    .o_active (o_active),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected activity / completion in the cycle following edge (arm + j).
  task automatic model(input int j, input logic [1:0] mode, input int delay, input int dur,
                       output bit act, output bit dn);
    int durp;
    int s;
    durp = (dur == 0) ? 1 : dur;
    act  = 1'b0;
    dn   = 1'b0;
    if (j >= delay) begin
      s = j - delay;
      case (mode)
        2'b00: act = 1'b1;
        2'b01: begin act = (s == 0); dn = (s >= 1); end
        2'b10: begin act = (s < durp); dn = (s >= durp); end
        default: act = (((s / durp) % 2) == 0);
      endcase
    end
  endtask

  function automatic logic [W-1:0] fault(input logic [W-1:0] d, input logic [W-1:0] m,
                                         input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return d & ~m;
      2'b01:   return d | m;
      default: return d ^ m;
    endcase
  endfunction

  task automatic randomize_cfg_inputs();
    i_mask  = W'($urandom);
    i_ctrl  = 2'($urandom);
    i_mode  = 2'($urandom);
    i_delay = CW'($urandom);
    i_dur   = CW'($urandom);
  endtask

  // Arm at the current negedge, then check len cycles. Config inputs are
  // scrambled after arming and stray arms are issued while not yet done.
  task automatic run_seq(input string tag, input logic [W-1:0] mask, input logic [1:0] ctrl,
                         input logic [1:0] mode, input int delay, input int dur, input int len,
                         input bit rnd_data, input logic [W-1:0] fixed_data, input bit do_clear);
    bit act, dn;
    logic [W-1:0] exp_d;
    i_arm   = 1'b1;
    i_clear = 1'b0;
    i_mask  = mask;
    i_ctrl  = ctrl;
    i_mode  = mode;
    i_delay = CW'(delay);
    i_dur   = CW'(dur);
    i_data  = rnd_data ? W'($urandom) : fixed_data;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      model(j, mode, delay, dur, act, dn);
      exp_d = fault(i_data, act ? mask : '0, ctrl);
      chk($sformatf("%s j=%0d active", tag, j), 32'(o_active), 32'(act));
      chk($sformatf("%s j=%0d done", tag, j), 32'(o_done), 32'(dn));
      chk($sformatf("%s j=%0d data", tag, j), 32'(o_data), 32'(exp_d));
      randomize_cfg_inputs();
      i_data = rnd_data ? W'($urandom) : fixed_data;
      i_arm  = (!dn && (j != len - 1)) ? 1'($urandom) : 1'b0;
    end
    i_arm = 1'b0;
    if (do_clear) begin
      i_clear = 1'b1;
      @(negedge clk);
      chk({tag, " clear active"}, 32'(o_active), 32'd0);
      chk({tag, " clear done"}, 32'(o_done), 32'd0);
      chk({tag, " clear data"}, 32'(o_data), 32'(i_data));
      i_clear = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] mode;
    int delay, dur, len, durp;
    bit clr;

    rst_n   = 1'b0;
    i_arm   = 1'b0;
    i_clear = 1'b0;
    i_data  = '0;
    i_mask  = '0;
    i_ctrl  = '0;
    i_mode  = '0;
    i_delay = '0;
    i_dur   = '0;

    // Reset values with arbitrary inputs.
    for (int i = 0; i < 4; i++) begin
      randomize_cfg_inputs();
      i_data  = W'($urandom);
      i_arm   = 1'($urandom);
      i_delay = '0;
      #3;
      chk("reset active", 32'(o_active), 32'd0);
      chk("reset done", 32'(o_done), 32'd0);
      chk("reset data", 32'(o_data), 32'(i_data));
    end
    @(negedge clk);
    i_arm = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Transient stuck-at-1, then re-arm directly from DONE with a window flip.
    run_seq("transient_sa1", 8'h81, 2'b01, 2'b01, 3, 0, 7, 1'b0, 8'h00, 1'b0);
    run_seq("window_flip", 8'hFF, 2'b10, 2'b10, 0, 4, 7, 1'b0, 8'hA5, 1'b1);
    run_seq("intermittent_sa0", 8'h0F, 2'b00, 2'b11, 0, 2, 10, 1'b0, 8'hFF, 1'b1);

    // Boundary counts: dur=0 window and maximum delay without wrap.
    run_seq("dur0_window", 8'h3C, 2'b11, 2'b10, 1, 0, 4, 1'b1, 8'h00, 1'b1);
    run_seq("max_delay", 8'hF0, 2'b01, 2'b01, (1 << CW) - 1, 7, (1 << CW) + 2, 1'b0, 8'h0F, 1'b1);

    // Clear and arm together during a permanent injection: clear wins.
    run_seq("perm_pre_abort", 8'h3C, 2'b10, 2'b00, 1, 3, 3, 1'b1, 8'h00, 1'b0);
    i_arm   = 1'b1;
    i_clear = 1'b1;
    i_delay = '0;
    @(negedge clk);
    chk("abort active", 32'(o_active), 32'd0);
    chk("abort done", 32'(o_done), 32'd0);
    chk("abort data", 32'(o_data), 32'(i_data));
    i_arm   = 1'b0;
    i_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_data = W'($urandom);
      @(negedge clk);
      chk("post_abort active", 32'(o_active), 32'd0);
      chk("post_abort data", 32'(o_data), 32'(i_data));
    end

    // Asynchronous reset in the middle of WAIT: no injection afterwards.
    i_arm = 1'b1; i_mask = 8'hFF; i_ctrl = 2'b01; i_mode = 2'b00;
    i_delay = CW'(6); i_dur = CW'(1); i_data = 8'h00;
    @(negedge clk);
    i_arm = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_wait active", 32'(o_active), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("after_rst active", 32'(o_active), 32'd0);
      chk("after_rst data", 32'(o_data), 32'(i_data));
      i_data = W'($urandom);
    end

    // Asynchronous reset during injection reverts o_data at once.
    i_arm = 1'b1; i_mask = 8'hFF; i_ctrl = 2'b01; i_mode = 2'b00;
    i_delay = '0; i_data = 8'h00;
    @(negedge clk);
    i_arm = 1'b0;
    chk("inject_pre_rst active", 32'(o_active), 32'd1);
    chk("inject_pre_rst data", 32'(o_data), 32'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inject active", 32'(o_active), 32'd0);
    chk("rst_inject data", 32'(o_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized sequences.
    for (int t = 0; t < 40; t++) begin
      mode  = 2'($urandom);
      delay = int'($urandom_range(0, 6));
      dur   = int'($urandom_range(0, 5));
      durp  = (dur == 0) ? 1 : dur;
      clr   = (mode == 2'b00 || mode == 2'b11) ? 1'b1 : 1'($urandom);
      len   = clr ? int'($urandom_range(1, 15)) : delay + durp + 1 + int'($urandom_range(0, 3));
      run_seq($sformatf("rand%0d", t), W'($urandom), 2'($urandom), mode, delay, dur, len,
              1'b1, 8'h00, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
